instr_sequencer: RTL and testbench

Cycle-level sequencer for the 8-bit CPU core. It drives the fetch/execute phase bit `sm` into the control-signal decoder and handles the core's run, halt and single-step behaviour. It stretches phases that touch RAM until RAM signals ready, and commits each phase with a single-cycle `cyc_valid` strobe that gates register, PC and IR writes. It also counts retired instructions and flags RAM timeouts.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/seq_wait_timer.sv | 36 +++
 rtl/instr_sequencer.sv | 124 ++++++++++++
 tb/tb_instr_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state codes, phase
// constants and parameter defaults.
package seq_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned WAIT_MAX_DEF = 15;

  localparam logic FETCH_PHASE = 1'b0;
  localparam logic EXEC_PHASE  = 1'b1;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_FETCH     = 3'd1;
  localparam seq_state_t ST_EXEC      = 3'd2;
  localparam seq_state_t ST_STEP_WAIT = 3'd3;
  localparam seq_state_t ST_HALTED    = 3'd4;
  localparam seq_state_t ST_ERROR     = 3'd5;

  // Phase bit presented to the decoder; HALTED holds the execute phase.
  function automatic logic phase_of(input seq_state_t s);
    return ((s == ST_EXEC) || (s == ST_HALTED)) ? EXEC_PHASE : FETCH_PHASE;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/status bundle between the core and the instruction sequencer.
//   master: drives start, step_mode, step, halt, mem_op, mem_ready
//   slave : drives sm, cyc_valid, running, halted, timeout_err, retired
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = seq_pkg::CNT_W_DEF
);
  logic             start;
  logic             step_mode;
  logic             step;
  logic             halt;
  logic             mem_op;
  logic             mem_ready;
  logic             sm;
  logic             cyc_valid;
  logic             running;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, step_mode, step, halt, mem_op, mem_ready,
    input  sm, cyc_valid, running, halted, timeout_err, retired
  );

  modport slave (
    input  start, step_mode, step, halt, mem_op, mem_ready,
    output sm, cyc_valid, running, halted, timeout_err, retired
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Consecutive RAM-miss timer for one phase.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart counting (phase entry / completion)
//   en         : current phase is waiting on RAM
//   mem_ready  : RAM completes this cycle
//   expire     : this miss is the WAIT_MAX-th in a row (never when WAIT_MAX=0)
module seq_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic mem_ready,
  output logic expire
);

  localparam int unsigned TW = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);

  logic [TW-1:0] cnt_q;

  // Miss counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !mem_ready) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expire = (WAIT_MAX != 0) && en && !mem_ready &&
                  (cnt_q == TW'(WAIT_MAX - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 8-bit core: run/halt/single-step control,
// RAM wait stretching, per-phase commit strobe, retired count, RAM timeout.
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_sequencer_if.slave (inputs start, step_mode, step, halt,
//                mem_op, mem_ready; outputs sm, cyc_valid, running, halted,
//                timeout_err, retired)
// Build option: INSTR_SEQ_STEP_EN enables single-step (STEP_WAIT state).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.slave   bus
);

  seq_state_t       state_q, state_nx;
  logic [CNT_W-1:0] retired_q;
  logic             phase_done;
  logic             wait_en;
  logic             wait_clr;
  logic             expire;
  logic             step_rise;

  // Phase completion: FETCH needs RAM, EXEC needs RAM only for memory ops.
  assign phase_done = ((state_q == ST_FETCH) && bus.mem_ready) ||
                      ((state_q == ST_EXEC) && (!bus.mem_op || bus.mem_ready));
  assign wait_en    = (state_q == ST_FETCH) || ((state_q == ST_EXEC) && bus.mem_op);
  assign wait_clr   = !((state_q == ST_FETCH) || (state_q == ST_EXEC)) || phase_done;

  assign bus.cyc_valid = phase_done;
  assign bus.retired   = retired_q;

  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wait_clr),
    .en        (wait_en),
    .mem_ready (bus.mem_ready),
    .expire    (expire)
  );

`ifdef INSTR_SEQ_STEP_EN
  logic step_q;

  // Step edge detector; only consulted in STEP_WAIT so other edges drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end

  assign step_rise = bus.step & ~step_q;
`else
  logic unused_step;
  assign step_rise   = 1'b0;
  assign unused_step = bus.step ^ bus.step_mode ^ step_rise;
`endif

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ready) state_nx = ST_EXEC;
        else if (expire)   state_nx = ST_ERROR;
      end
      ST_EXEC: begin
        if (phase_done) begin
          if (bus.halt)           state_nx = ST_HALTED;
`ifdef INSTR_SEQ_STEP_EN
          else if (bus.step_mode) state_nx = ST_STEP_WAIT;
`endif
          else                    state_nx = ST_FETCH;
        end else if (expire) begin
          state_nx = ST_ERROR;
        end
      end
`ifdef INSTR_SEQ_STEP_EN
      ST_STEP_WAIT: begin
        if (step_rise || !bus.step_mode) state_nx = ST_FETCH;
      end
`endif
      ST_HALTED: begin
        if (bus.start) state_nx = ST_FETCH;
      end
      ST_ERROR: begin
        state_nx = ST_ERROR;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register, registered status decodes and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      bus.sm          <= FETCH_PHASE;
      bus.running     <= 1'b0;
      bus.halted      <= 1'b0;
      bus.timeout_err <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q         <= state_nx;
      bus.sm          <= phase_of(state_nx);
      bus.running     <= (state_nx == ST_FETCH) || (state_nx == ST_EXEC);
      bus.halted      <= (state_nx == ST_HALTED);
      bus.timeout_err <= (state_nx == ST_ERROR);
      if ((state_q == ST_EXEC) && phase_done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one 16-bit/WAIT_MAX=15 instance and one
// 4-bit/WAIT_MAX=0 instance (cheap counter wrap, disabled timeout).
module tb_instr_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_ret;

  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(16)) b1 ();
  instr_sequencer_if #(.CNT_W(4))  b2 ();

  instr_sequencer #(.CNT_W(16), .WAIT_MAX(15)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  instr_sequencer #(.CNT_W(4), .WAIT_MAX(0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    b1.start = 0; b1.step_mode = 0; b1.step = 0; b1.halt = 0; b1.mem_op = 0; b1.mem_ready = 1;
    b2.start = 0; b2.step_mode = 0; b2.step = 0; b2.halt = 0; b2.mem_op = 0; b2.mem_ready = 1;
    repeat (2) tick();

    check("rst_sm", 32'(b1.sm), 0);
    check("rst_cv", 32'(b1.cyc_valid), 0);
    check("rst_running", 32'(b1.running), 0);
    check("rst_halted", 32'(b1.halted), 0);
    check("rst_terr", 32'(b1.timeout_err), 0);
    check("rst_retired", 32'(b1.retired), 0);

    rst_n = 1'b1;
    tick();
    check("idle_running", 32'(b1.running), 0);

    // Three zero-wait non-memory instructions.
    b1.start = 1;
    tick();
    b1.start = 0;
    for (int i = 0; i < 3; i++) begin
      check("run_sm_fetch", 32'(b1.sm), 0);
      check("run_cv_fetch", 32'(b1.cyc_valid), 1);
      tick();
      check("run_sm_exec", 32'(b1.sm), 1);
      check("run_cv_exec", 32'(b1.cyc_valid), 1);
      tick();
    end
    check("run_retired3", 32'(b1.retired), 3);
    check("run_running", 32'(b1.running), 1);

    // Memory EXEC with four RAM wait cycles.
    b1.mem_op = 1;
    tick();
    b1.mem_ready = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("memw_sm", 32'(b1.sm), 1);
      check("memw_cv", 32'(b1.cyc_valid), 0);
      tick();
    end
    b1.mem_ready = 1;
    #1;
    check("memw_cv_done", 32'(b1.cyc_valid), 1);
    check("memw_sm_done", 32'(b1.sm), 1);
    tick();
    check("memw_back_fetch", 32'(b1.sm), 0);
    check("memw_retired4", 32'(b1.retired), 4);
    b1.mem_op = 0;

    // halt and step_mode together: HALTED wins.
    tick();
    b1.halt = 1; b1.step_mode = 1;
    #1;
    check("halt_cv", 32'(b1.cyc_valid), 1);
    tick();
    check("halt_halted", 32'(b1.halted), 1);
    check("halt_sm", 32'(b1.sm), 1);
    check("halt_running", 32'(b1.running), 0);
    check("halt_retired5", 32'(b1.retired), 5);
    check("halt_cv_off", 32'(b1.cyc_valid), 0);
    b1.halt = 0; b1.step_mode = 0;
    repeat (2) tick();
    check("halt_hold", 32'(b1.halted), 1);
    b1.start = 1;
    tick();
    b1.start = 0;
    check("resume_sm", 32'(b1.sm), 0);
    check("resume_halted", 32'(b1.halted), 0);
    check("resume_running", 32'(b1.running), 1);

`ifdef INSTR_SEQ_STEP_EN
    // Single-step: held step advances exactly one instruction.
    b1.step_mode = 1;
    tick();
    tick();
    check("step_wait_running", 32'(b1.running), 0);
    check("step_wait_sm", 32'(b1.sm), 0);
    check("step_retired6", 32'(b1.retired), 6);
    b1.step = 1;
    repeat (10) tick();
    check("step_hold_retired7", 32'(b1.retired), 7);
    check("step_hold_running", 32'(b1.running), 0);
    b1.step = 0;
    tick();
    b1.step = 1;
    tick();
    check("step2_fetch", 32'(b1.running), 1);
    b1.step = 0;
    tick();
    b1.step = 1;  // edge during EXEC must not be queued
    tick();
    check("step2_retired8", 32'(b1.retired), 8);
    tick();
    check("step_no_queue", 32'(b1.running), 0);
    check("step_no_queue_ret", 32'(b1.retired), 8);
    b1.step_mode = 0;
    tick();
    check("step_mode_drop", 32'(b1.running), 1);
    b1.step = 0;
    exp_ret = 8;
`else
    // Single-step not built: step_mode is ignored.
    b1.step_mode = 1;
    tick();
    tick();
    check("nostep_running", 32'(b1.running), 1);
    check("nostep_retired6", 32'(b1.retired), 6);
    b1.step_mode = 0;
    exp_ret = 6;
`endif

    // FETCH timeout after 15 consecutive misses; sticky until reset.
    b1.mem_ready = 0;
    repeat (14) tick();
    check("to_before_running", 32'(b1.running), 1);
    check("to_before_terr", 32'(b1.timeout_err), 0);
    tick();
    check("to_terr", 32'(b1.timeout_err), 1);
    check("to_running", 32'(b1.running), 0);
    check("to_sm", 32'(b1.sm), 0);
    b1.start = 1; b1.mem_ready = 1;
    repeat (3) tick();
    check("to_sticky", 32'(b1.timeout_err), 1);
    check("to_start_ignored", 32'(b1.running), 0);
    check("to_retired", 32'(b1.retired), 32'(exp_ret));
    rst_n = 1'b0;
    #1;
    check("to_rst_terr", 32'(b1.timeout_err), 0);
    check("to_rst_retired", 32'(b1.retired), 0);
    b1.start = 0;
    tick();
    rst_n = 1'b1;

    // Second instance: WAIT_MAX=0 never times out.
    b2.start = 1;
    tick();
    b2.mem_ready = 0;
    repeat (20) tick();
    check("nto_running", 32'(b2.running), 1);
    check("nto_terr", 32'(b2.timeout_err), 0);
    check("nto_sm", 32'(b2.sm), 0);
    b2.mem_ready = 1;
    repeat (30) tick();
    check("b2_retired15", 32'(b2.retired), 15);
    check("b2_sm_fetch", 32'(b2.sm), 0);

    // Reset mid-EXEC wait with a full counter.
    b2.mem_op = 1;
    tick();
    b2.mem_ready = 0;
    repeat (3) tick();
    check("b2_wait_sm", 32'(b2.sm), 1);
    check("b2_wait_retired", 32'(b2.retired), 15);
    rst_n = 1'b0;
    #1;
    check("b2_rst_sm", 32'(b2.sm), 0);
    check("b2_rst_cv", 32'(b2.cyc_valid), 0);
    check("b2_rst_running", 32'(b2.running), 0);
    check("b2_rst_halted", 32'(b2.halted), 0);
    check("b2_rst_terr", 32'(b2.timeout_err), 0);
    check("b2_rst_retired", 32'(b2.retired), 0);
    b2.mem_op = 0; b2.mem_ready = 1;
    tick();
    rst_n = 1'b1;

    // Counter wrap: 16 instructions on a 4-bit counter.
    tick();
    check("wrap_fetch", 32'(b2.running), 1);
    repeat (30) tick();
    check("wrap_retired15", 32'(b2.retired), 15);
    tick();
    check("wrap_cv", 32'(b2.cyc_valid), 1);
    check("wrap_pre", 32'(b2.retired), 15);
    tick();
    check("wrap_zero", 32'(b2.retired), 0);
    check("wrap_sm", 32'(b2.sm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
